// File: rtl/core_step_ctrl.sv
// core_step_ctrl: turns slow-clock ticks into core clock enables under run/step/halt button control.
// Define STEP_BURST_EN to issue STEP_BURST enables per step press instead of one.
module core_step_ctrl #(
  parameter int DB_CYCLES  = 240000,
  parameter int CNT_W      = 16,
  parameter int STEP_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             halt_req,
  output logic             core_en,
  output logic             running,
  output logic [CNT_W-1:0] step_count
);
  localparam int DB_W = $clog2(DB_CYCLES);
  typedef enum logic [1:0] {HALT, STEP_WAIT, RUN} state_t;
  state_t state_q, state_d;
  logic core_en_q, core_en_d, running_q, running_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic [1:0] raw, press;
  assign raw = {btn_run, btn_step};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0] sync_q, sync_d;
    logic acc_q, acc_d, prs_q, prs_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    always_comb begin
      sync_d = {sync_q[0], raw[i]};
      acc_d = acc_q;
      cnt_d = '0;
      if (sync_q[1] != acc_q) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
          acc_d = sync_q[1];
          cnt_d = '0;
        end
      end
      prs_d = acc_d & ~acc_q;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
        acc_q <= 1'b0;
        prs_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        sync_q <= sync_d;
        acc_q <= acc_d;
        prs_q <= prs_d;
        cnt_q <= cnt_d;
      end
    end
    assign press[i] = prs_q;
  end
`ifdef STEP_BURST_EN
  localparam int BW = $clog2(STEP_BURST + 1);
  logic [BW-1:0] burst_q, burst_d;
`endif
  always_comb begin
    state_d = state_q;
    core_en_d = 1'b0;
`ifdef STEP_BURST_EN
    burst_d = burst_q;
`endif
    case (state_q)
      HALT: begin
        state_d = press[1] ? RUN : press[0] ? STEP_WAIT : HALT;
`ifdef STEP_BURST_EN
        if (!press[1] && press[0]) burst_d = BW'(STEP_BURST);
`endif
      end
      STEP_WAIT: begin
`ifdef STEP_BURST_EN
        if (press[1] || halt_req) state_d = HALT;
        else if (tick) begin
          core_en_d = 1'b1;
          burst_d = burst_q - 1'b1;
          if (burst_q <= BW'(1)) state_d = HALT;
        end
`else
        if (press[1]) state_d = HALT;
        else if (tick) begin
          core_en_d = 1'b1;
          state_d = HALT;
        end
`endif
      end
      RUN: begin
        if (press[1] || halt_req) state_d = HALT;
        else core_en_d = tick;
      end
      default: state_d = HALT;
    endcase
    running_d = state_d == RUN;
    step_count_d = step_count_q + CNT_W'(core_en_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HALT;
      core_en_q <= 1'b0;
      running_q <= 1'b0;
      step_count_q <= '0;
`ifdef STEP_BURST_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      core_en_q <= core_en_d;
      running_q <= running_d;
      step_count_q <= step_count_d;
`ifdef STEP_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end
  assign core_en = core_en_q;
  assign running = running_q;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_core_step_ctrl.sv
// tb_core_step_ctrl: directed checks of run/step/halt control, debounce and step counting.
module tb_core_step_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, btn_step = 1'b0, btn_run = 1'b0, halt_req = 1'b0;
  logic core_en, running;
  logic [3:0] step_count;
  int total = 0, bad = 0, en_seen = 0;
  core_step_ctrl #(.DB_CYCLES(4), .CNT_W(4), .STEP_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_step(btn_step), .btn_run(btn_run),
    .halt_req(halt_req), .core_en(core_en), .running(running), .step_count(step_count)
  );
  always #5 clk = ~clk;
`ifdef STEP_BURST_EN
  localparam int STEPS_PER_PRESS = 4;
  localparam int HELD_HALT_STEPS = 0;
`else
  localparam int STEPS_PER_PRESS = 1;
  localparam int HELD_HALT_STEPS = 1;
`endif
  task automatic step();
    @(posedge clk);
    #1;
    en_seen += int'(core_en);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (gap - 1) step();
    end
  endtask
  task automatic press_btn(input bit run);
    if (run) btn_run = 1'b1; else btn_step = 1'b1;
    repeat (10) step();
    btn_run = 1'b0;
    btn_step = 1'b0;
    repeat (8) step();
  endtask
  initial begin
    repeat (3) step();
    chk("reset_core_en", core_en, 0);
    chk("reset_running", running, 0);
    chk("reset_count", step_count, 0);
    rst_n = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick = (i % 10 == 9);
      step();
    end
    tick = 1'b0;
    chk("idle_en", en_seen, 0);
    chk("idle_running", running, 0);
    chk("idle_count", step_count, 0);
    btn_step = 1'b1;
    repeat (6) step();
    tick = 1'b1;
    step();
    chk("tick_same_as_press", core_en, 0);
    step();
    chk("step_en", core_en, 1);
    tick = 1'b0;
    step();
    chk("step_en_width", core_en, 0);
    chk("step_count1", step_count, 1);
    chk("step_running", running, 0);
    step();
    btn_step = 1'b0;
    repeat (8) step();
    en_seen = 0;
    ticks(3, 10);
    chk("halt_drop", en_seen, 0);
    chk("halt_count", step_count, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    press_btn(1);
    chk("run_running", running, 1);
    en_seen = 0;
    ticks(20, 4);
    chk("run_en20", en_seen, 20);
    chk("run_wrap", step_count, 4);
    press_btn(1);
    chk("run_off", running, 0);
    en_seen = 0;
    ticks(5, 4);
    chk("run_off_en", en_seen, 0);
    press_btn(1);
    ticks(2, 4);
    chk("pre_reset_count", step_count, 6);
    rst_n = 1'b0;
    tick = 1'b1;
    step();
    chk("midrst_en", core_en, 0);
    chk("midrst_running", running, 0);
    chk("midrst_count", step_count, 0);
    rst_n = 1'b1;
    tick = 1'b0;
    step();
    en_seen = 0;
    ticks(3, 4);
    chk("midrst_halted", en_seen, 0);
    press_btn(1);
    tick = 1'b1;
    step();
    chk("run_en", core_en, 1);
    tick = 1'b0;
    repeat (2) step();
    halt_req = 1'b1;
    tick = 1'b1;
    step();
    chk("halt_req_tick_en", core_en, 0);
    chk("halt_req_running", running, 0);
    halt_req = 1'b0;
    tick = 1'b0;
    step();
    en_seen = 0;
    ticks(3, 4);
    chk("halt_req_after", en_seen, 0);
    chk("halt_req_count", step_count, 1);
    halt_req = 1'b1;
    press_btn(0);
    en_seen = 0;
    ticks(6, 4);
    halt_req = 1'b0;
    chk("step_with_halt_req", en_seen, HELD_HALT_STEPS);
    en_seen = 0;
    for (int i = 0; i < 30; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      tick = (i % 5 == 4);
      step();
    end
    btn_step = 1'b0;
    tick = 1'b0;
    repeat (8) step();
    ticks(2, 4);
    chk("bounce_en", en_seen, 0);
    press_btn(0);
    en_seen = 0;
    ticks(6, 4);
    chk("stable_step_en", en_seen, STEPS_PER_PRESS);
    chk("stable_running", running, 0);
`ifdef STEP_BURST_EN
    press_btn(0);
    en_seen = 0;
    ticks(2, 4);
    chk("burst_pre_rst", en_seen, 2);
    rst_n = 1'b0;
    step();
    chk("burst_rst_en", core_en, 0);
    chk("burst_rst_count", step_count, 0);
    rst_n = 1'b1;
    ticks(4, 4);
    chk("burst_after_rst", en_seen, 2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_step_ctrl.md
Name: core_step_ctrl

Overview:
- Consumes the one-cycle `tick` pulse from the slow-clock divider and turns it into the single-cycle core's clock enable `core_en`.
- Board buttons select the mode:
  - free-run: one core cycle per tick;
  - single-step: one core cycle per button press, issued on the next tick;
  - halt.
- The core's `halt_req` (ebreak/trap) forces halt.
- Sits between the slow-clock divider and the core's state-update enables.

Parameters:
- DB_CYCLES, 240000, clk cycles a synchronized button must hold a new level before it is accepted (20 ms @ 12 MHz); must be >= 2.
- CNT_W, 16, width of the retired-step counter.
- STEP_BURST, 4, core enables issued per step press; used only when STEP_BURST_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- tick  in  1  one-cycle pulse from the slow-clock divider.
- btn_step  in  1  raw asynchronous step button, active-high.
- btn_run  in  1  raw asynchronous run/halt toggle button, active-high.
- halt_req  in  1  core request to stop; level, sampled every cycle.
- core_en  out  1  one-cycle enable to the core; registered.
- running  out  1  high while in RUN.
- step_count  out  CNT_W  number of core_en pulses issued since reset.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - State HALT; core_en=0, running=0, step_count=0.
  - Synchronizers and debouncers are cleared to a released-button level.
  - Applies mid-operation and overrides everything, including a tick in the same cycle.
- Button path, per button:
  - 2-flop synchronizer, then debounce counter.
  - Counter resets whenever the synchronized level equals the accepted level.
  - On reaching DB_CYCLES-1 while the level differs, the accepted level updates.
  - A rising edge of the accepted level gives a one-cycle `press` strobe.
  - Latency from raw press to press strobe: 2 + DB_CYCLES cycles. Releases produce no strobe.
- FSM states: HALT, STEP_WAIT, RUN.
  - HALT:
    - run press -> RUN.
    - Else step press -> STEP_WAIT.
    - Simultaneous presses: run wins.
  - STEP_WAIT:
    - On tick: core_en=1 the following cycle, -> HALT.
    - run press (with or without tick) -> HALT with no enable issued (abort).
    - Further step presses are ignored.
  - RUN:
    - Each tick gives core_en=1 the following cycle.
    - run press or halt_req=1 -> HALT. A tick in that same cycle produces no enable; halt has priority.
  - halt_req in HALT or STEP_WAIT: no effect. Single-step past a breakpoint is allowed.
- core_en:
  - Registered; exactly 1 cycle wide; exactly one per accepted tick; latency tick -> core_en is 1 cycle.
  - Ticks arriving in HALT are dropped, not queued.
- step_count:
  - Increments in the same cycle core_en is driven high (visible one cycle later).
  - Wraps from 2^CNT_W-1 to 0, no saturation.
- running: registered decode of state==RUN; updates in the cycle after the transition.

Optional Feature:
- Macro: STEP_BURST_EN.
- Defined:
  - A step press in HALT loads a burst counter with STEP_BURST.
  - STEP_WAIT then issues one core_en per tick and decrements the counter.
  - It returns to HALT after the STEP_BURST-th enable.
  - run press or halt_req aborts the burst to HALT. An enable already issued is not retracted; halt_req in the same cycle as a tick blocks that tick's enable.
- Undefined:
  - Exactly one enable per step press.
  - halt_req is ignored in STEP_WAIT.
  - No burst counter logic is synthesized.

Test Plan (bench uses DB_CYCLES=4, CNT_W=4):
- Reset then idle 50 cycles with tick every 10 cycles -> core_en never high, running=0, step_count=0.
- btn_step held high 10 cycles -> press strobe 6 cycles after the rising edge. The next tick gives core_en=1 for 1 cycle, then HALT. step_count=1; later ticks give no core_en.
- btn_run press, then 20 ticks -> running=1 and 20 core_en pulses. step_count wraps 15->0 and reads 4. A second run press -> running=0 and core_en stops.
- In RUN, assert halt_req in the same cycle as a tick -> no core_en for that tick, state HALT, running=0 next cycle.
- btn_step toggling every 2 cycles for 30 cycles (bounce) -> no press accepted and no core_en. Then hold it stable -> exactly one step.
- With STEP_BURST_EN and STEP_BURST=4: one step press plus 6 ticks -> exactly 4 core_en pulses, then HALT. Repeat with rst_n=0 after the 2nd pulse -> outputs clear next cycle and no further core_en.
